// File: rtl/fp8_pkg.sv
// Shared FP8 definitions: format defaults, field helpers, saturation constant,
// flag bit positions and the divider control state encoding.
package fp8_pkg;

    localparam int unsigned FP8_EXP_BITS  = 4;
    localparam int unsigned FP8_MANT_BITS = 3;
    localparam int unsigned FP8_BIAS      = (1 << (FP8_EXP_BITS - 1)) - 1;
    localparam int unsigned FP8_W         = 1 + FP8_EXP_BITS + FP8_MANT_BITS;

    // Largest magnitude {exp, mant}; all-ones exponent is an ordinary value here.
    localparam logic [FP8_W-2:0] FP8_MAX_MAG = '1;

    // Bit positions inside the 3-bit {dz, ovf, unf} flag vector.
    localparam int unsigned FLAG_DZ  = 2;
    localparam int unsigned FLAG_OVF = 1;
    localparam int unsigned FLAG_UNF = 0;

    typedef enum logic [1:0] {
        StWaitA,
        StWaitB,
        StResult
    } state_e;

    function automatic logic fp8_sign(input logic [FP8_W-1:0] x);
        return x[FP8_W-1];
    endfunction

    function automatic logic [FP8_EXP_BITS-1:0] fp8_exp(input logic [FP8_W-1:0] x);
        return x[FP8_MANT_BITS +: FP8_EXP_BITS];
    endfunction

    function automatic logic [FP8_MANT_BITS-1:0] fp8_mant(input logic [FP8_W-1:0] x);
        return x[FP8_MANT_BITS-1:0];
    endfunction

endpackage

// File: rtl/fp8_log_div_core.sv
// Combinational Mitchell log-domain divider: mantissa subtract with borrow into
// the exponent difference, then zero/overflow/underflow handling.
module fp8_log_div_core
    import fp8_pkg::*;
#(
    parameter int unsigned EXP_BITS      = FP8_EXP_BITS,
    parameter int unsigned MANTISSA_BITS = FP8_MANT_BITS,
    parameter int unsigned BIAS          = (1 << (EXP_BITS - 1)) - 1,
    localparam int unsigned W            = 1 + EXP_BITS + MANTISSA_BITS
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] q_o,
    output logic [2:0]   flags_o
);

    // Two guard bits keep Ea - Eb + BIAS - borrow exact and signed.
    localparam int unsigned EW = EXP_BITS + 2;
    localparam logic signed [EW-1:0] BiasS  = EW'(BIAS);
    localparam logic signed [EW-1:0] ExpMax = EW'((1 << EXP_BITS) - 1);

    logic                     sq;
    logic [EXP_BITS-1:0]      ea, eb;
    logic [MANTISSA_BITS-1:0] ma, mb, mq;
    logic                     borrow;
    logic signed [EW-1:0]     eq;

    assign sq = a_i[W-1] ^ b_i[W-1];
    assign ea = a_i[MANTISSA_BITS +: EXP_BITS];
    assign eb = b_i[MANTISSA_BITS +: EXP_BITS];
    assign ma = a_i[MANTISSA_BITS-1:0];
    assign mb = b_i[MANTISSA_BITS-1:0];

    // Modular subtract gives 2^M + Ma - Mb truncated when a borrow occurs.
    assign borrow = (ma < mb);
    assign mq     = ma - mb;
    assign eq     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BiasS
                  - $signed({{(EW-1){1'b0}}, borrow});

    // Special cases resolved in priority order: divide-by-zero, zero dividend, ovf, unf.
    always_comb begin
        q_o     = {sq, eq[EXP_BITS-1:0], mq};
        flags_o = 3'b000;
        if (eb == '0) begin
            q_o              = {sq, {(W-1){1'b1}}};
            flags_o[FLAG_DZ] = 1'b1;
        end else if (ea == '0) begin
            q_o = {sq, {(W-1){1'b0}}};
        end else if (eq > ExpMax) begin
            q_o               = {sq, {(W-1){1'b1}}};
            flags_o[FLAG_OVF] = 1'b1;
        end else if (eq[EW-1] || (eq == '0)) begin
            q_o               = {sq, {(W-1){1'b0}}};
            flags_o[FLAG_UNF] = 1'b1;
        end
    end

endmodule

// File: rtl/fp8_log_divider.sv
// Byte-serial approximate FP8 divider: dividend then divisor over one operand
// handshake, quotient and {dz, ovf, unf} returned on a result handshake.
// Optional macro FP8_DIV_STICKY_EN adds accumulated sticky flags with clr_flags.
module fp8_log_divider
    import fp8_pkg::*;
#(
    parameter int unsigned EXP_BITS      = FP8_EXP_BITS,
    parameter int unsigned MANTISSA_BITS = FP8_MANT_BITS,
    parameter int unsigned BIAS          = (1 << (EXP_BITS - 1)) - 1,
    localparam int unsigned W            = 1 + EXP_BITS + MANTISSA_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic [2:0]   out_flags,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic         clr_flags,
    output logic [2:0]   sticky_flags
);

    state_e       state_q, state_d;
    logic [W-1:0] a_q;
    logic [W-1:0] out_data_q;
    logic [2:0]   out_flags_q;
    logic [W-1:0] q_w;
    logic [2:0]   flags_w;
    logic         load_a, load_res;

    fp8_log_div_core #(
        .EXP_BITS     (EXP_BITS),
        .MANTISSA_BITS(MANTISSA_BITS),
        .BIAS         (BIAS)
    ) u_core (
        .a_i    (a_q),
        .b_i    (in_data),
        .q_o    (q_w),
        .flags_o(flags_w)
    );

    // Handshake decode and next-state; RESULT never bypasses straight to a new A.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        load_a   = 1'b0;
        load_res = 1'b0;
        unique case (state_q)
            StWaitA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_a  = 1'b1;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_res = 1'b1;
                    state_d  = StResult;
                end
            end
            StResult: begin
                if (out_ready) begin
                    state_d = StWaitA;
                end
            end
            default: state_d = StWaitA;
        endcase
    end

    // State, latched dividend and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitA;
            a_q         <= '0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_a) begin
                a_q <= in_data;
            end
            if (load_res) begin
                out_data_q  <= q_w;
                out_flags_q <= flags_w;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;
    assign out_valid = (state_q == StResult);

`ifdef FP8_DIV_STICKY_EN
    logic [2:0] sticky_q, sticky_d;

    // New result flags take precedence over a same-cycle clear.
    always_comb begin
        sticky_d = sticky_q;
        if (load_res) begin
            sticky_d = clr_flags ? flags_w : (sticky_q | flags_w);
        end else if (clr_flags) begin
            sticky_d = 3'b000;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_clr_flags;
    assign unused_clr_flags = clr_flags;
    assign sticky_flags     = 3'b000;
`endif

endmodule

// File: tb/tb_fp8_log_divider.sv
// Directed plus randomized bench for fp8_log_divider against a log-domain model.
module tb_fp8_log_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic [2:0] out_flags;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       clr_flags = 1'b0;
    logic [2:0] sticky_flags;

    int total = 0;
    int bad = 0;
    logic [2:0] sticky_m = 3'b000;

    always #5 clk = ~clk;

    fp8_log_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_flags   (out_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .clr_flags   (clr_flags),
        .sticky_flags(sticky_flags)
    );

    // Values as fixed-point log2 in eighths: log2(x) ~ (E - BIAS) + M/8.
    // Returns {flags[2:0], q[7:0]}.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
        int la, lb, d, e;
        logic s;
        logic [2:0] m;
        s = a[7] ^ b[7];
        if (b[6:3] == 4'd0) return {3'b100, s, 7'h7F};
        if (a[6:3] == 4'd0) return {3'b000, s, 7'h00};
        la = 8 * int'(a[6:3]) + int'(a[2:0]);
        lb = 8 * int'(b[6:3]) + int'(b[2:0]);
        d  = la - lb + 8 * 7;
        m  = d[2:0];
        e  = (d - int'(m)) / 8;
        if (e > 15) return {3'b010, s, 7'h7F};
        if (e <= 0) return {3'b001, s, 7'h00};
        return {3'b000, s, e[3:0], m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input string tag, input logic [7:0] d, input logic clr);
        int n;
        n = 0;
        @(negedge clk);
        in_data   = d;
        in_valid  = 1'b1;
        clr_flags = clr;
        while (!in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input logic clr);
        logic [10:0] m;
        m = model(a, b);
        put(tag, a, 1'b0);
        check({tag, "_valid_after_a"}, 32'(out_valid), 32'd0);
        put(tag, b, clr);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(m[7:0]));
        check({tag, "_flags"}, 32'(out_flags), 32'(m[10:8]));
`ifdef FP8_DIV_STICKY_EN
        sticky_m = clr ? m[10:8] : (sticky_m | m[10:8]);
`endif
        check({tag, "_sticky"}, 32'(sticky_flags), 32'(sticky_m));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(m[7:0]));
            check({tag, "_hold_flags"}, 32'(out_flags), 32'(m[10:8]));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_flags"}, 32'(out_flags), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_sticky"}, 32'(sticky_flags), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        #12;
        check_reset_outputs("por");
        #7;
        rst_n = 1'b1;

        run("basic", 8'h4C, 8'h40, 0, 1'b0);
        run("borrow", 8'h3C, 8'h3E, 0, 1'b0);
        run("sign_bp", 8'hC0, 8'h40, 5, 1'b0);
        run("dz", 8'h40, 8'h00, 1, 1'b0);
        run("ovf", 8'h78, 8'h08, 0, 1'b0);
        run("unf_clr", 8'h08, 8'h78, 0, 1'b1);
        run("zero_a", 8'h00, 8'h40, 0, 1'b0);
        run("ovf2", 8'hF8, 8'h08, 0, 1'b0);

        // Clear while idle.
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
`ifdef FP8_DIV_STICKY_EN
        sticky_m = 3'b000;
`endif
        check("idle_clr_sticky", 32'(sticky_flags), 32'(sticky_m));

        // Reset with A latched: stale A must not be used afterwards.
        put("rst_a", 8'h40, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_a");
        sticky_m = 3'b000;
        #2;
        rst_n = 1'b1;
        run("after_rst", 8'h4C, 8'h40, 0, 1'b0);

        // Reset with a pending result: it must be dropped.
        run("pre_drop", 8'h78, 8'h08, 0, 1'b0);
        put("rst_r", 8'h4C, 1'b0);
        put("rst_r", 8'h40, 1'b0);
        check("rst_r_pending", 32'(out_valid), 32'd1);
        #4;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_r");
        sticky_m = 3'b000;
        #2;
        rst_n = 1'b1;
        run("after_drop", 8'h3C, 8'h3E, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run("rand", ra, rb, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
